// File: rtl/vga_out.sv
// rtl/vga_out.sv - VGA timing generator streaming RGB pixels out of a FIFO
module vga_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [24:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS       = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS       = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {PREFILL, RUN} state_e;

  state_e        state_q, state_d;
  logic [1:0]    rst_sync_q;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, vsync_q, de_q, rd_q, underflow_q;
  logic          run, visible, h_sync_on, v_sync_on;
  logic          unused_bit24;

  assign unused_bit24 = fifo_dout[24];

  // Assertion follows rst at once; release reaches the FSM two clocks later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run        = (state_q == RUN);
  assign visible    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign h_sync_on  = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END);
  assign v_sync_on  = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END);
  assign fifo_rd_en = run && visible && !fifo_empty;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      PREFILL: begin
        if (rst_sync_q[1] && !fifo_empty) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: state_d = PREFILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PREFILL;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      de_q        <= 1'b0;
      rd_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsync_q <= !(run && h_sync_on);
      vsync_q <= !(run && v_sync_on);
      de_q    <= run && visible;
      rd_q    <= fifo_rd_en;
      if (run && visible && fifo_empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // FIFO data lands one cycle after the strobe, alongside the registered de.
  assign {red, green, blue} = (de_q && rd_q) ? fifo_dout[23:0] : 24'h0;

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = de_q;
  assign underflow = underflow_q;

endmodule

// File: doc/vga_out.md
VGA_OUT -- requirements
Module: vga_out

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Ports:
- clk  in  1  pixel clock, rising edge.
- rst  in  1  reset; one clock, reset asynchronous and active-low.
- fifo_empty  in  1  high when the pixel FIFO holds no word.
- fifo_dout  in  25  FIFO read data; bits [23:16] R, [15:8] G, [7:0] B, bit 24 ignored.
- fifo_rd_en  out  1  FIFO read strobe; data valid on fifo_dout the following cycle.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- de  out  1  data enable, high on visible pixels.
- red, green, blue  out  8 each  pixel colour.
- underflow  out  1  sticky flag: a visible pixel found the FIFO empty.

Function
REQ-006 The block SHALL keep h_cnt (0..H_TOTAL-1, H_TOTAL = sum of horizontal parameters) and v_cnt (0..V_TOTAL-1). h_cnt increments every cycle in RUN. On h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. On v_cnt = V_TOTAL-1 with the same h_cnt wrap, v_cnt wraps to 0.
REQ-007 Visible region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. Sync pulse: h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], with the vertical equivalent on v_cnt.
REQ-008 Two-state FSM:
- PREFILL: counters held at 0; outputs at reset values. Move to RUN on the first cycle fifo_empty = 0.
- RUN: free-running timing. The FSM never returns to PREFILL except through reset.
REQ-009 fifo_rd_en SHALL be combinational: state = RUN, visible region, and fifo_empty = 0.
REQ-010 hsync, vsync, and de SHALL be registered from the counter decode. All outputs are aligned with one cycle of latency after the counters.
REQ-011 red/green/blue SHALL equal fifo_dout fields on cycles where de = 1 and a read was issued in the previous cycle. Otherwise they SHALL be 0.
REQ-012 Underflow: a visible-region cycle with fifo_empty = 1 SHALL:
- issue no read;
- output black for that pixel;
- set underflow to 1 on the next cycle.
Timing SHALL continue undisturbed. underflow is cleared only by reset.
REQ-013 Simultaneous h and v wrap SHALL produce h_cnt = 0, v_cnt = 0 in one cycle with no skipped or duplicated line.
REQ-014 Total reads per frame with no underflow SHALL be H_ACTIVE*V_ACTIVE (307200 at defaults).

Reset
REQ-015 rst = 0 SHALL immediately, without waiting for clk, force:
- state = PREFILL, h_cnt = 0, v_cnt = 0;
- hsync = 1, vsync = 1, de = 0;
- red/green/blue = 0, underflow = 0, fifo_rd_en = 0.
REQ-016 Reset asserted mid-line or mid-frame SHALL abandon the frame. After release, the block re-enters PREFILL and waits for fifo_empty = 0.
REQ-017 Reset release SHALL be synchronised internally; the first state change occurs no earlier than the second rising clk after rst rises.

Verification
REQ-018 Hold fifo_empty = 1 after reset -> fifo_rd_en, de stay 0; hsync = vsync = 1 indefinitely.
REQ-019 Keep FIFO non-empty, run one frame -> exactly 307200 rd_en pulses. hsync low 96 cycles starting 656 cycles after line start. Line period 800. vsync low for 2 lines (1600 cycles) starting at line 490. Frame period 420000 cycles.
REQ-020 Feed fifo_dout = 0x0ABCDEF on the first read -> red = 0xAB, green = 0xCD, blue = 0xEF on the first de cycle, one cycle after the read.
REQ-021 Force fifo_empty = 1 for 3 cycles at pixel (100, 10) -> 3 black pixels, no rd_en during them, underflow = 1 from the next cycle. hsync/vsync positions unchanged. underflow still 1 at the next frame.
REQ-022 Assert rst = 0 at h_cnt = 300, v_cnt = 200 -> all outputs at reset values in the same cycle. After release with fifo_empty = 0, the first de follows 1 cycle after PREFILL exit, at h_cnt = 0, v_cnt = 0.
REQ-023 Observe the last pixel of the frame (h_cnt = 799, v_cnt = 524) -> the next cycle shows h_cnt = 0, v_cnt = 0, and de rises one cycle later.
